// File: rtl/clause_eval_pkg.sv
// Shared types and helpers for the sequential clause evaluator.
package clause_eval_pkg;

  typedef enum logic [1:0] {CS_OPEN, CS_SAT, CS_UNIT, CS_CONFLICT} clause_status_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} eval_state_t;

  function automatic int unsigned n_chunks(input int unsigned vpc, input int unsigned sw);
    return (vpc + sw - 1) / sw;
  endfunction

  // Status priority: satisfied beats everything, then no free literal, then exactly one.
  function automatic clause_status_t resolve_status(input logic sat, input logic [1:0] ucnt);
    if (sat) return CS_SAT;
    if (ucnt == 2'd0) return CS_CONFLICT;
    if (ucnt == 2'd1) return CS_UNIT;
    return CS_OPEN;
  endfunction

endpackage

// File: rtl/clause_chunk_eval.sv
// Combinational evaluation of one chunk of SUB_WIDTH literal lanes:
// satisfied flag, saturating unassigned count and lowest unassigned lane.
module clause_chunk_eval #(
  parameter int unsigned SUB_WIDTH = 5,
  parameter int unsigned LANE_BITS = 3
) (
  input  logic [SUB_WIDTH-1:0] i_mask,
  input  logic [SUB_WIDTH-1:0] i_unassign,
  input  logic [SUB_WIDTH-1:0] i_pole,
  input  logic [SUB_WIDTH-1:0] i_val,
  output logic                 o_chunk_sat_c,
  output logic [1:0]           o_ucnt_c,
  output logic [LANE_BITS-1:0] o_fidx_c,
  output logic                 o_fpole_c
);

  logic w_found;

  always_comb begin
    o_chunk_sat_c = 1'b0;
    o_ucnt_c      = 2'd0;
    o_fidx_c      = '0;
    o_fpole_c     = 1'b0;
    w_found       = 1'b0;
    for (int i = 0; i < int'(SUB_WIDTH); i++) begin
      if (i_mask[i] && !i_unassign[i] && (i_val[i] ^ i_pole[i])) begin
        o_chunk_sat_c = 1'b1;
      end
      if (i_mask[i] && i_unassign[i]) begin
        if (!w_found) begin
          o_fidx_c  = LANE_BITS'(i);
          o_fpole_c = i_pole[i];
          w_found   = 1'b1;
        end
        if (o_ucnt_c != 2'd2) begin
          o_ucnt_c = o_ucnt_c + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_clause_evaluator.sv
// Multi-cycle clause evaluator scanning SUB_WIDTH literals per cycle.
// Optional early exit on a satisfied chunk: define SEQ_CLAUSE_EARLY_EXIT_EN.
`ifndef VAR_PER_CLAUSE
`define VAR_PER_CLAUSE 10
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module seq_clause_evaluator
  import clause_eval_pkg::*;
#(
  parameter int unsigned VAR_PER_CLAUSE = `VAR_PER_CLAUSE,
  parameter int unsigned SUB_WIDTH      = 5,
  parameter int unsigned VAR_BITS       = `MAX_VARS_BITS
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [VAR_PER_CLAUSE-1:0]          unassign,
  input  logic [VAR_PER_CLAUSE-1:0]          clause_mask,
  input  logic [VAR_PER_CLAUSE-1:0]          clause_pole,
  input  logic [VAR_PER_CLAUSE-1:0]          val,
  input  logic [VAR_PER_CLAUSE*VAR_BITS-1:0] variable,
  output logic                               out_valid,
  input  logic                               out_ready,
  output clause_status_t                     status,
  output logic [VAR_BITS-1:0]                implied_variable,
  output logic                               new_val
);

  localparam int unsigned N_CH = n_chunks(VAR_PER_CLAUSE, SUB_WIDTH);
  localparam int unsigned PAD  = N_CH * SUB_WIDTH;
  localparam int unsigned CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned LW   = (SUB_WIDTH > 1) ? $clog2(SUB_WIDTH) : 1;
  localparam int unsigned FW   = (VAR_PER_CLAUSE > 1) ? $clog2(VAR_PER_CLAUSE) : 1;

  eval_state_t                        r_state, w_state_nxt;
  logic [CW-1:0]                      r_chunk;
  logic [PAD-1:0]                     r_unassign, r_mask, r_pole, r_val;
  logic [VAR_PER_CLAUSE*VAR_BITS-1:0] r_variable;
  logic                               r_sat, r_fpole;
  logic [1:0]                         r_ucnt;
  logic [FW-1:0]                      r_fidx;

  logic [SUB_WIDTH-1:0] w_c_mask, w_c_unassign, w_c_pole, w_c_val;
  logic [FW-1:0]        w_c_base;
  logic                 w_c_sat, w_c_lpole;
  logic [1:0]           w_c_ucnt;
  logic [LW-1:0]        w_c_lidx;

  logic                 w_accept, w_last, w_exit, w_load_result;
  logic                 w_sat_m, w_fpole_m;
  logic [2:0]           w_usum;
  logic [1:0]           w_ucnt_m;
  logic [FW-1:0]        w_fidx_m;
  logic [VAR_BITS-1:0]  w_ivar_m;
  clause_status_t       w_status_m;
  logic                 w_in_ready_nxt, w_out_valid_nxt;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_chunk == CW'(N_CH - 1));
`ifdef SEQ_CLAUSE_EARLY_EXIT_EN
  assign w_exit   = w_last || w_c_sat;
`else
  assign w_exit   = w_last;
`endif

  // Chunk-select mux; padding lanes past the clause carry a zero mask.
  always_comb begin
    w_c_mask     = '0;
    w_c_unassign = '0;
    w_c_pole     = '0;
    w_c_val      = '0;
    w_c_base     = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (r_chunk == CW'(c)) begin
        w_c_mask     = r_mask[c*SUB_WIDTH +: SUB_WIDTH];
        w_c_unassign = r_unassign[c*SUB_WIDTH +: SUB_WIDTH];
        w_c_pole     = r_pole[c*SUB_WIDTH +: SUB_WIDTH];
        w_c_val      = r_val[c*SUB_WIDTH +: SUB_WIDTH];
        w_c_base     = FW'(c * SUB_WIDTH);
      end
    end
  end

  clause_chunk_eval #(
    .SUB_WIDTH (SUB_WIDTH),
    .LANE_BITS (LW)
  ) u_chunk (
    .i_mask        (w_c_mask),
    .i_unassign    (w_c_unassign),
    .i_pole        (w_c_pole),
    .i_val         (w_c_val),
    .o_chunk_sat_c (w_c_sat),
    .o_ucnt_c      (w_c_ucnt),
    .o_fidx_c      (w_c_lidx),
    .o_fpole_c     (w_c_lpole)
  );

  // Merge the current chunk into the running accumulators.
  always_comb begin
    w_usum    = 3'(r_ucnt) + 3'(w_c_ucnt);
    w_sat_m   = r_sat | w_c_sat;
    w_ucnt_m  = (w_usum >= 3'd2) ? 2'd2 : w_usum[1:0];
    w_fidx_m  = r_fidx;
    w_fpole_m = r_fpole;
    if ((r_ucnt == 2'd0) && (w_c_ucnt != 2'd0)) begin
      w_fidx_m  = w_c_base + FW'(w_c_lidx);
      w_fpole_m = w_c_lpole;
    end
    w_status_m = resolve_status(w_sat_m, w_ucnt_m);
    w_ivar_m   = '0;
    for (int i = 0; i < int'(VAR_PER_CLAUSE); i++) begin
      if (w_fidx_m == FW'(i)) begin
        w_ivar_m = r_variable[i*VAR_BITS +: VAR_BITS];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_exit)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
    w_load_result   = (r_state == ST_SCAN) && (w_state_nxt == ST_DONE);
  end

  // Result registers change only on SCAN->DONE, so DONE outputs stay stable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      status           <= CS_OPEN;
      implied_variable <= '0;
      new_val          <= 1'b0;
    end else begin
      in_ready  <= w_in_ready_nxt;
      out_valid <= w_out_valid_nxt;
      if (w_load_result) begin
        status           <= w_status_m;
        implied_variable <= (w_status_m == CS_UNIT) ? w_ivar_m : '0;
        new_val          <= (w_status_m == CS_UNIT) ? ~w_fpole_m : 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_chunk    <= '0;
      r_unassign <= '0;
      r_mask     <= '0;
      r_pole     <= '0;
      r_val      <= '0;
      r_variable <= '0;
      r_sat      <= 1'b0;
      r_ucnt     <= 2'd0;
      r_fidx     <= '0;
      r_fpole    <= 1'b0;
    end else if (w_accept) begin
      r_chunk    <= '0;
      r_unassign <= PAD'(unassign);
      r_mask     <= PAD'(clause_mask);
      r_pole     <= PAD'(clause_pole);
      r_val      <= PAD'(val);
      r_variable <= variable;
      r_sat      <= 1'b0;
      r_ucnt     <= 2'd0;
      r_fidx     <= '0;
      r_fpole    <= 1'b0;
    end else if (r_state == ST_SCAN) begin
      r_chunk <= r_chunk + CW'(1);
      r_sat   <= w_sat_m;
      r_ucnt  <= w_ucnt_m;
      r_fidx  <= w_fidx_m;
      r_fpole <= w_fpole_m;
    end
  end

endmodule

// File: tb/tb_seq_clause_evaluator.sv
// Directed plus randomized bench for seq_clause_evaluator against a literal-level model.
module tb_seq_clause_evaluator;
  import clause_eval_pkg::*;

  localparam int VPC = 10;
  localparam int SW  = 5;
  localparam int VB  = 8;
  localparam int NCH = (VPC + SW - 1) / SW;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [VPC-1:0]   unassign, clause_mask, clause_pole, val;
  logic [VPC*VB-1:0] vars;
  logic             out_valid;
  logic             out_ready;
  clause_status_t   status;
  logic [VB-1:0]    implied_variable;
  logic             new_val;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  seq_clause_evaluator #(
    .VAR_PER_CLAUSE (VPC),
    .SUB_WIDTH      (SW),
    .VAR_BITS       (VB)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .unassign         (unassign),
    .clause_mask      (clause_mask),
    .clause_pole      (clause_pole),
    .val              (val),
    .variable         (vars),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .status           (status),
    .implied_variable (implied_variable),
    .new_val          (new_val)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: evaluate literals one by one, then apply status priority.
  function automatic void model(output int st, output int iv, output int nv, output int lat);
    int cnt = 0, first = -1, fsat = -1;
    for (int i = 0; i < VPC; i++) begin
      if (clause_mask[i]) begin
        if (unassign[i]) begin
          cnt++;
          if (first < 0) first = i;
        end else if ((val[i] ^ clause_pole[i]) && fsat < 0) begin
          fsat = i;
        end
      end
    end
    iv = 0; nv = 0;
    if (fsat >= 0)     st = 1;
    else if (cnt == 0) st = 3;
    else if (cnt == 1) st = 2;
    else               st = 0;
    if (st == 2) begin
      iv = int'(vars[first*VB +: VB]);
      nv = clause_pole[first] ? 0 : 1;
    end
    lat = NCH + 1;
`ifdef SEQ_CLAUSE_EARLY_EXIT_EN
    if (fsat >= 0) lat = fsat / SW + 2;
`endif
  endfunction

  task automatic set_clause(input logic [VPC-1:0] m, input logic [VPC-1:0] p,
                            input logic [VPC-1:0] u, input logic [VPC-1:0] v);
    clause_mask = m; clause_pole = p; unassign = u; val = v;
  endtask

  task automatic default_vars();
    for (int i = 0; i < VPC; i++) vars[i*VB +: VB] = VB'(i * 3 + 10);
    vars[9*VB +: VB] = VB'(37);
  endtask

  // Submit the current operands, check latency/result, hold back-pressure bp cycles.
  task automatic run_clause(input string tag, input int bp);
    int st, iv, nv, lat, cyc;
    model(st, iv, nv, lat);
    @(negedge clock);
    out_ready = (bp == 0);
    in_valid  = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    unassign = VPC'($urandom); val = VPC'($urandom);
    clause_mask = VPC'($urandom); clause_pole = VPC'($urandom);
    vars = {$urandom, $urandom, $urandom};
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    check({tag, ".status"}, 32'(status), 32'(st));
    check({tag, ".implied_variable"}, 32'(implied_variable), 32'(iv));
    check({tag, ".new_val"}, 32'(new_val), 32'(nv));
    check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int k = 0; k < bp; k++) begin
      @(posedge clock); #1;
      check({tag, ".bp_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".bp_status"}, 32'(status), 32'(st));
      check({tag, ".bp_in_ready"}, 32'(in_ready), 32'd0);
    end
    if (bp > 0) begin
      @(negedge clock);
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
    check({tag, ".release_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".release_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_clause('0, '0, '0, '0);
    default_vars();
    repeat (2) @(posedge clock);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.status", 32'(status), 32'(CS_OPEN));
    check("rst.implied_variable", 32'(implied_variable), 32'd0);
    check("rst.new_val", 32'(new_val), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    default_vars(); set_clause(10'h3FF, 10'h000, 10'h200, 10'h000);
    run_clause("unit_chunk1", 0);
    default_vars(); set_clause(10'h3FF, 10'h200, 10'h200, 10'h000);
    run_clause("neg_unit", 0);
    default_vars(); set_clause(10'h1FF, 10'h200, 10'h200, 10'h000);
    run_clause("masked_conflict", 0);
    default_vars(); set_clause(10'h3FF, 10'h000, 10'h300, 10'h002);
    run_clause("sat_chunk0", 0);
    default_vars(); set_clause(10'h3FF, 10'h000, 10'h084, 10'h000);
    run_clause("open_2chunks", 0);
    default_vars(); set_clause(10'h37F, 10'h000, 10'h084, 10'h000);
    run_clause("unit_lit2", 0);
    default_vars(); set_clause(10'h000, 10'h3FF, 10'h3FF, 10'h3FF);
    run_clause("all_masked", 0);
    default_vars(); set_clause(10'h3FF, 10'h000, 10'h000, 10'h200);
    run_clause("sat_chunk1", 0);
    default_vars(); set_clause(10'h3FF, 10'h000, 10'h200, 10'h000);
    run_clause("backpressure", 4);
    default_vars(); set_clause(10'h3FF, 10'h000, 10'h084, 10'h000);
    run_clause("after_bp", 0);

    // Abort a clause in its first scan cycle.
    default_vars(); set_clause(10'h3FF, 10'h000, 10'h200, 10'h000);
    @(negedge clock);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clock); #1;
    check("rst_scan.out_valid", 32'(out_valid), 32'd0);
    check("rst_scan.in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      check("rst_scan.no_result", 32'(out_valid), 32'd0);
    end
    default_vars(); set_clause(10'h3FF, 10'h200, 10'h200, 10'h000);
    run_clause("after_rst", 0);

    for (int n = 0; n < 40; n++) begin
      logic [VPC-1:0] p;
      p = VPC'($urandom);
      vars = {$urandom, $urandom, $urandom};
      set_clause(($urandom_range(0, 1) == 1) ? 10'h3FF : VPC'($urandom), p,
                 VPC'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 2) != 0) ? p : VPC'($urandom));
      run_clause("random", $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_clause_evaluator.md
# seq_clause_evaluator

Multi-cycle, parametrised clause evaluator for the BCP datapath. It accepts one clause of up to `VAR_PER_CLAUSE` literals and scans it `SUB_WIDTH` literals per cycle. It accumulates the satisfied flag, the unassigned-literal count and the first unassigned literal across chunks, then reports one of four statuses: OPEN, SAT, UNIT or CONFLICT. For a UNIT result it also reports the implied variable and its value. It sits between the clause fetch stage and the implication queue, and handshakes with each on valid/ready.

## Interface
- `VAR_PER_CLAUSE`, default `` `VAR_PER_CLAUSE ``: literals per clause (≥1).
- `SUB_WIDTH`, default 5: literals evaluated per cycle (1..VAR_PER_CLAUSE).
- `VAR_BITS`, default `` `MAX_VARS_BITS ``: variable index width.
- `clock` input 1: single clock.
- `reset_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: clause operands valid.
- `in_ready` output 1: block idle and able to accept.
- `unassign` input VAR_PER_CLAUSE: 1 = literal's variable is unassigned.
- `clause_mask` input VAR_PER_CLAUSE: 1 = literal slot is used.
- `clause_pole` input VAR_PER_CLAUSE: 1 = negated literal.
- `val` input VAR_PER_CLAUSE: current variable value (ignored when unassigned).
- `variable` input VAR_PER_CLAUSE×VAR_BITS: variable index per slot.
- `out_valid` output 1: result valid; held until accepted.
- `out_ready` input 1: consumer accepts the result.
- `status` output 2: `clause_status_t`.
- `implied_variable` output VAR_BITS: the variable of the single unassigned literal (meaningful on UNIT).
- `new_val` output 1: value implied for that variable, equal to `~clause_pole` of that slot (meaningful on UNIT).

## Operation
- Literal semantics:
  - A literal is active when `clause_mask[i]` is set.
  - It is satisfied when it is active, assigned, and `val[i] ^ clause_pole[i]` equals 1.
  - It counts as unassigned when it is active and `unassign[i]` is set.
- N_CHUNKS = ceil(VAR_PER_CLAUSE/SUB_WIDTH). Lanes beyond VAR_PER_CLAUSE in the last chunk are treated as masked.
- On an `in_valid && in_ready` cycle, all operands are registered and the accumulators are cleared: `sat`=0, `ucnt`=0, and first-unassigned (`fidx`, `fpole`)=0.
- FSM: IDLE → SCAN → DONE → IDLE.
  - IDLE: `in_ready`=1. Acceptance moves to SCAN with chunk counter 0.
  - SCAN: evaluate chunk k and merge it into the accumulators:
    - `sat |= chunk_sat`.
    - `ucnt` saturates at 2.
    - `fidx`/`fpole` capture the lowest-index unassigned literal seen so far.
    - Leave SCAN after the last chunk (k = N_CHUNKS-1), or earlier per the Configuration section.
  - DONE: `out_valid`=1 and all outputs are stable. `out_ready` returns to IDLE.
- Status priority:
  1. SAT if `sat`.
  2. Otherwise CONFLICT if `ucnt`=0.
  3. Otherwise UNIT if `ucnt`=1.
  4. Otherwise OPEN.
- An all-masked clause reports CONFLICT.
- `implied_variable` and `new_val` are driven to 0 unless status is UNIT.
- Inputs are sampled only on acceptance; changes during SCAN or DONE are ignored.

## Timing
- Reset (`reset_n`=0 at a rising edge): state IDLE, `in_ready`=1, `out_valid`=0, `status`=OPEN, `implied_variable`=0, `new_val`=0.
- Reset mid-SCAN or mid-DONE aborts the operation with no result emitted.
- Latency: acceptance at edge 0, chunk k evaluated in cycle k+1, `out_valid` high from cycle N_CHUNKS+1.
- Throughput is one clause per N_CHUNKS+2 cycles when `out_ready` is held high. There is no acceptance in the same cycle as a DONE→IDLE transition.
- Back-pressure: DONE holds indefinitely while `out_ready`=0, with outputs unchanged.

## Configuration
- `SEQ_CLAUSE_EARLY_EXIT_EN` defined: when the chunk under evaluation contains a satisfied literal, the FSM goes SCAN→DONE on the next edge. A SAT result can then appear as early as cycle 2.
- Not defined: all N_CHUNKS are always scanned, giving a fixed latency of N_CHUNKS+1.
- Status and values are identical in both builds.

## Structure
- `clause_eval_pkg` holds:
  - `typedef enum logic [1:0] {CS_OPEN, CS_SAT, CS_UNIT, CS_CONFLICT} clause_status_t`.
  - The FSM state enum.
  - A `n_chunks(VAR_PER_CLAUSE, SUB_WIDTH)` function.
- Sub-module `clause_chunk_eval`: combinational, SUB_WIDTH lanes. Outputs are `chunk_sat`, a 2-bit saturating unassigned count, and the lowest unassigned lane index with its pole. It is instantiated once, fed by a chunk-select mux.

## Test plan
Configuration for all scenarios: VAR_PER_CLAUSE=10, SUB_WIDTH=5 (N_CHUNKS=2), `clause_mask`=10'h3FF, `clause_pole`=0, `out_ready`=1 unless stated.
- Unit in second chunk: `unassign`=10'h200, `val`=0, `variable[9]`=37 → UNIT, `implied_variable`=37, `new_val`=1, `out_valid` exactly at cycle 3.
- Negated unit: as above with `clause_pole`=10'h200 → UNIT, `new_val`=0. Then set `clause_mask`=10'h1FF with `unassign`=10'h200 → CONFLICT.
- SAT in chunk 0: `unassign`=10'h300, `val`=10'h002 → SAT. `out_valid` at cycle 2 with `SEQ_CLAUSE_EARLY_EXIT_EN`, at cycle 3 without it.
- Open across chunks: `unassign`=10'h084 (lits 2 and 7), `val`=0 → OPEN, `implied_variable`=0. With `clause_mask`=10'h37F (lit 7 masked) → UNIT, `implied_variable`=`variable[2]`.
- Back-pressure: `out_ready`=0 for 4 cycles → `out_valid` and `status` stable, `in_ready`=0. Release → IDLE on the next edge, then a new clause is accepted.
- Reset mid-SCAN: `reset_n`=0 at cycle 1 → at the next edge `out_valid`=0 and `in_ready`=1, no result emitted. The next clause evaluates correctly.
